// File: rtl/uart_output_port_pkg.sv
// Shared types and helpers for the CPU OUT-port UART serialiser.
package uart_output_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int BYTES_PER_WORD = 4;

    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_output_port_fifo.sv
// Synchronous word FIFO with combinational head read; push on a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int BITS  = 32,
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [BITS-1:0]          data_in,
    output logic [BITS-1:0]          data_out,
    output logic [$clog2(WORDS):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = AW + 1;

    logic [BITS-1:0] mem [WORDS];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(WORDS));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // Pointers wrap on their own since WORDS is a power of two.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_output_port.sv
// Queues CPU OUT words and serialises them as 8N1 UART, four bytes per word, LSB byte first.
module uart_output_port
    import uart_output_port_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic [31:0]                   word_in,
    input  logic                          word_valid,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int BCW     = $clog2(DIVISOR);
    localparam logic [BCW-1:0] BAUD_RELOAD = BCW'(DIVISOR - 1);
    localparam logic [1:0]     LAST_BYTE   = 2'(BYTES_PER_WORD - 1);

    uart_state_e     state, state_n;
    logic [BCW-1:0]  baud_cnt, baud_n;
    logic [2:0]      bit_idx, bit_n;
    logic [1:0]      byte_idx, byte_n;
    logic [31:0]     shreg, shreg_n;
    logic [7:0]      cur_byte;
    logic            tx_n;
    logic            bit_done;
    logic            pop;
    logic            push_acc;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [31:0]     fifo_data;

    sync_fifo #(.BITS(32), .WORDS(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push_acc),
        .pop      (pop),
        .data_in  (word_in),
        .data_out (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign push_acc = word_valid & (~fifo_full | pop);
    assign drop     = word_valid & ~push_acc;
    assign busy     = (state != ST_IDLE) | ~fifo_empty;
    assign bit_done = (baud_cnt == '0);

    always_comb begin
        state_n  = state;
        baud_n   = bit_done ? BAUD_RELOAD : baud_cnt - BCW'(1);
        bit_n    = bit_idx;
        byte_n   = byte_idx;
        shreg_n  = shreg;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_n = BAUD_RELOAD;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_data;
                    byte_n  = '0;
                    state_n = ST_START;
                end
            end
            ST_START: if (bit_done) begin
                bit_n   = '0;
                state_n = ST_DATA;
            end
            ST_DATA: if (bit_done) begin
                if (bit_idx == 3'd7) state_n = ST_STOP;
                else                 bit_n   = bit_idx + 3'd1;
            end
            ST_STOP: if (bit_done) begin
                // Chain straight into the next word so back-to-back words have no idle gap.
                if (byte_idx != LAST_BYTE) begin
                    byte_n  = byte_idx + 2'd1;
                    shreg_n = {8'h00, shreg[31:8]};
                    state_n = ST_START;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_data;
                    byte_n  = '0;
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // tx is registered from next-state values so the line changes on the same edge as the state.
    assign cur_byte = shreg_n[7:0];
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            ST_START: tx_n = 1'b0;
            ST_DATA:  tx_n = cur_byte[bit_n];
            default:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            overflow <= overflow | drop;
        end
    end

endmodule
